// File: rtl/pair_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pair_sequencer
//  Purpose  : Enumerates integer pairs (a, b) with limit >= a > b >= 1,
//             a ascending (outer), b ascending (inner), and offers each pair
//             on a valid/ready handshake. In primitive mode only pairs with
//             (a-b) odd and gcd(a,b) == 1 are offered; the gcd is found by
//             repeated subtraction, one step per clock.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1        clock, rising edge
//    rst_n          in   1        synchronous active-low reset
//    start          in   1        begin enumeration (sampled in IDLE only)
//    limit          in   N_WIDTH  largest a to emit, latched at start
//    primitive_only in   1        1 = primitive pairs only, latched at start
//    a_out          out  32       current a, zero-extended
//    b_out          out  32       current b, zero-extended
//    pair_valid     out  1        a_out/b_out hold an offered pair
//    pair_ready     in   1        consumer accepts the pair
//    busy           out  1        high in every state except IDLE
//    done           out  1        one-cycle pulse at end of enumeration
//    pair_count     out  32       pairs transferred since last start
// ============================================================================
module pair_sequencer #(
  parameter int N_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_WIDTH-1:0] limit,
  input  logic               primitive_only,
  output logic [31:0]        a_out,
  output logic [31:0]        b_out,
  output logic               pair_valid,
  input  logic               pair_ready,
  output logic               busy,
  output logic               done,
  output logic [31:0]        pair_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_GCD     = 3'd2;
  localparam logic [2:0] S_OFFER   = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [N_WIDTH-1:0] a_q, a_d;
  logic [N_WIDTH-1:0] b_q, b_d;
  logic [N_WIDTH-1:0] x_q, x_d;
  logic [N_WIDTH-1:0] y_q, y_d;
  logic [N_WIDTH-1:0] limit_q, limit_d;
  logic               prim_q, prim_d;
  logic [31:0]        count_q, count_d;

  // b+1 computed one bit wider so the compare against a cannot wrap.
  logic [N_WIDTH:0]   w_b_inc;
  assign w_b_inc = {1'b0, b_q} + (N_WIDTH+1)'(1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      limit_q <= '0;
      prim_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      limit_q <= limit_d;
      prim_q  <= prim_d;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    y_d     = y_q;
    limit_d = limit_q;
    prim_d  = prim_q;
    count_d = count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          limit_d = limit;
          prim_d  = primitive_only;
          count_d = '0;
          if (limit < N_WIDTH'(2)) begin
            state_d = S_DONE;
          end else begin
            a_d     = N_WIDTH'(2);
            b_d     = N_WIDTH'(1);
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (!prim_q) begin
          state_d = S_OFFER;
        end else if (a_q[0] == b_q[0]) begin
          // Equal LSBs means a-b is even: never primitive.
          state_d = S_ADVANCE;
        end else begin
          x_d     = a_q;
          y_d     = b_q;
          state_d = S_GCD;
        end
      end

      S_GCD: begin
        if (x_q == y_q) begin
          state_d = (x_q == N_WIDTH'(1)) ? S_OFFER : S_ADVANCE;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end

      S_OFFER: begin
        if (pair_ready) begin
          count_d = count_q + 32'd1;
          state_d = S_ADVANCE;
        end
      end

      S_ADVANCE: begin
        if (w_b_inc < {1'b0, a_q}) begin
          b_d     = w_b_inc[N_WIDTH-1:0];
          state_d = S_CHECK;
        end else if (a_q < limit_q) begin
          // a < limit guarantees a+1 fits, so a never wraps even at the
          // largest representable limit.
          a_d     = a_q + N_WIDTH'(1);
          b_d     = N_WIDTH'(1);
          state_d = S_CHECK;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: handshake flags depend on state only, never on pair_ready.
  // --------------------------------------------------------------------------
  always_comb begin
    pair_valid = (state_q == S_OFFER);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    a_out      = 32'(a_q);
    b_out      = 32'(b_q);
    pair_count = count_q;
  end

endmodule
`default_nettype wire
